// File: rtl/seg7_readback.sv
`default_nettype none
// ============================================================================
// Module   : seg7_readback
// Purpose  : Passive monitor on the multiplexed, active-low 7-segment drive of
//            the stopwatch display. Waits for {an, seg} to stay stable, then
//            decodes the segment pattern of the single selected digit back to
//            its hex nibble. Drives nothing onto the display pins.
// Ports    : clk          system clock
//            rst          synchronous active-high reset
//            an           anode enables, active-low (bit i low = digit i)
//            seg          segments, active-low, ordered {g,f,e,d,c,b,a}
//            digits       recovered nibbles, digit i at [4i+3:4i]
//            digit_valid  bit i = digit i last captured a legal hex glyph
//            frame_done   1-cycle pulse when every digit has been captured
//            bad_pattern  1-cycle pulse on a non-hex, non-blank capture
//            multi_err    1-cycle pulse per registered sample with 2+ anodes low
// Revision : 1.0 - initial release
// ============================================================================
module seg7_readback #(
   parameter int DIGITS = 4,
   parameter int SETTLE = 4   // legal range 1..255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGITS-1:0]     an,
   input  logic [6:0]            seg,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_done,
   output logic                  bad_pattern,
   output logic                  multi_err
);

   // Counter saturates its useful range at SETTLE-1 (at most 254).
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLING = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [7:0]          count;
   logic [7:0]          count_nxt;
   logic [DIGITS-1:0]   an_q;
   logic [6:0]          seg_q;
   logic [DIGITS-1:0]   seen;
   logic [DIGITS-1:0]   seen_nxt;
   logic [DIGITS-1:0]   sel;
   logic                changed;
   logic                in_one;
   logic                capture;
   logic [3:0]          glyph_val;
   logic                glyph_legal;
   logic                glyph_blank;

   // When a capture happens the registered sample has exactly one anode low,
   // so the inverted anodes form a one-hot digit select.
   assign sel      = ~an_q;
   assign seen_nxt = seen | sel;

   // ------------------------------------------------------------------------
   // Next-state / stability counter
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      capture   = 1'b0;
      changed   = ({an, seg} != {an_q, seg_q});
      in_one    = $onehot(~an);

      case (state)
         IDLE: begin
            count_nxt = 8'd0;
            if (in_one) begin
               state_nxt = SETTLING;
            end
         end
         SETTLING: begin
            if (changed) begin
               count_nxt = 8'd0;
               state_nxt = in_one ? SETTLING : IDLE;
            end else if (count == SETTLE_LAST) begin
               capture   = 1'b1;
               count_nxt = 8'd0;
               state_nxt = HELD;
            end else begin
               count_nxt = count + 8'd1;
            end
         end
         HELD: begin
            // Stable value already captured; only a change rearms.
            if (changed) begin
               count_nxt = 8'd0;
               state_nxt = in_one ? SETTLING : IDLE;
            end
         end
         default: begin
            count_nxt = 8'd0;
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Segment pattern to nibble, decoded from the registered sample
   // ------------------------------------------------------------------------
   always_comb begin
      glyph_val   = 4'h0;
      glyph_legal = 1'b1;
      glyph_blank = 1'b0;
      case (seg_q)
         7'b1000000: glyph_val = 4'h0;
         7'b1111001: glyph_val = 4'h1;
         7'b0100100: glyph_val = 4'h2;
         7'b0110000: glyph_val = 4'h3;
         7'b0011001: glyph_val = 4'h4;
         7'b0010010: glyph_val = 4'h5;
         7'b0000010: glyph_val = 4'h6;
         7'b1111000: glyph_val = 4'h7;
         7'b0000000: glyph_val = 4'h8;
         7'b0010000: glyph_val = 4'h9;
         7'b0001000: glyph_val = 4'hA;
         7'b0000011: glyph_val = 4'hB;
         7'b1000110: glyph_val = 4'hC;
         7'b0100001: glyph_val = 4'hD;
         7'b0000110: glyph_val = 4'hE;
         7'b0001110: glyph_val = 4'hF;
         7'b1111111: begin
            glyph_legal = 1'b0;
            glyph_blank = 1'b1;
         end
         default: glyph_legal = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // State, sample register and outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= 8'd0;
         an_q        <= '1;
         seg_q       <= '1;
         seen        <= '0;
         digits      <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         bad_pattern <= 1'b0;
         multi_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         an_q        <= an;
         seg_q       <= seg;
         frame_done  <= 1'b0;
         bad_pattern <= 1'b0;
         multi_err   <= !$onehot0(~an_q);

         if (capture) begin
            for (int d = 0; d < DIGITS; d++) begin
               if (sel[d]) begin
                  digits[4*d +: 4] <= glyph_val;
                  digit_valid[d]   <= glyph_legal;
               end
            end
            bad_pattern <= !glyph_legal && !glyph_blank;
            // Frame completion clears the mask in the same update.
            if (&seen_nxt) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen       <= seen_nxt;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_readback
// Purpose  : Self-checking bench for seg7_readback (DIGITS=4, SETTLE=4).
//            A run-length reference model predicts every output each cycle;
//            a glyph table and directed sequences add independent checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_readback;

   localparam int DIGITS = 4;
   localparam int SETTLE = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    an  = 4'hF;
   logic [6:0]    seg = 7'h7F;
   logic [15:0]   digits;
   logic [3:0]    digit_valid;
   logic          frame_done;
   logic          bad_pattern;
   logic          multi_err;

   seg7_readback #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .seg         (seg),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .bad_pattern (bad_pattern),
      .multi_err   (multi_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int step_no = 0;
   int frame_cnt = 0;
   int bad_cnt = 0;
   int multi_cnt = 0;
   int frame_at = -1;

   // Reference model: tracks how long the current {an,seg} has been seen.
   logic [10:0] m_prev;
   int          m_run;
   logic [3:0]  m_dig [4];
   logic [3:0]  m_vld;
   logic [3:0]  m_seen;
   logic        m_frame, m_bad, m_multi;

   function automatic logic [6:0] glyph_of(int v);
      case (v)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  15: return 7'b0001110;
         default: return 7'b1111111;
      endcase
   endfunction

   // 0..15 = hex glyph, 16 = blank, -1 = illegal
   function automatic int decode(logic [6:0] s);
      for (int j = 0; j < 16; j++) if (glyph_of(j) == s) return j;
      if (s == 7'b1111111) return 16;
      return -1;
   endfunction

   task automatic model_edge();
      int idx, g;
      logic [3:0] prev_an;
      if (rst) begin
         m_prev = '1; m_run = 0; m_vld = 0; m_seen = 0;
         m_frame = 0; m_bad = 0; m_multi = 0;
         for (int d = 0; d < 4; d++) m_dig[d] = 4'h0;
      end else begin
         prev_an = m_prev[10:7];
         m_multi = ($countones(~prev_an) >= 2);
         m_frame = 0;
         m_bad   = 0;
         if ({an, seg} == m_prev) m_run++;
         else m_run = 1;
         m_prev = {an, seg};
         if (m_run == SETTLE + 1 && $countones(~an) == 1) begin
            idx = 0;
            for (int d = 0; d < 4; d++) if (!an[d]) idx = d;
            g = decode(seg);
            if (g >= 0 && g < 16) begin
               m_dig[idx] = 4'(g); m_vld[idx] = 1'b1;
            end else begin
               m_dig[idx] = 4'h0;  m_vld[idx] = 1'b0; m_bad = (g < 0);
            end
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
               m_frame = 1; m_seen = 0;
            end
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Apply one sample, clock it, then compare all outputs against the model.
   task automatic step(logic [3:0] a, logic [6:0] s);
      an  = a;
      seg = s;
      @(posedge clk);
      model_edge();
      #1;
      step_no++;
      if (frame_done)  begin frame_cnt++; frame_at = step_no; end
      if (bad_pattern) bad_cnt++;
      if (multi_err)   multi_cnt++;
      chk("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
      chk("digit_valid", 32'(digit_valid), 32'(m_vld));
      chk("frame_done", 32'(frame_done), 32'(m_frame));
      chk("bad_pattern", 32'(bad_pattern), 32'(m_bad));
      chk("multi_err", 32'(multi_err), 32'(m_multi));
   endtask

   task automatic hold(logic [3:0] a, logic [6:0] s, int n);
      for (int i = 0; i < n; i++) step(a, s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(4'hF, 7'h7F);
      chk("reset_outputs", 32'({digits, digit_valid, frame_done, bad_pattern, multi_err}), 32'd0);
      rst = 1'b0;
      frame_cnt = 0; bad_cnt = 0; multi_cnt = 0; frame_at = -1;
   endtask

   typedef struct {
      logic [3:0] an;
      int         idx;
      logic [6:0] seg;
      logic [3:0] nib;
      logic       vld;
      int         bad;
   } vec_t;

   vec_t vt [18];

   initial begin
      int s0, k, hl;
      logic [3:0] a;
      logic [6:0] s;

      vt[0]  = '{4'b1110, 0, 7'b1000000, 4'h0, 1'b1, 0};
      vt[1]  = '{4'b1101, 1, 7'b1111001, 4'h1, 1'b1, 0};
      vt[2]  = '{4'b1011, 2, 7'b0100100, 4'h2, 1'b1, 0};
      vt[3]  = '{4'b0111, 3, 7'b0110000, 4'h3, 1'b1, 0};
      vt[4]  = '{4'b1110, 0, 7'b0011001, 4'h4, 1'b1, 0};
      vt[5]  = '{4'b1101, 1, 7'b0010010, 4'h5, 1'b1, 0};
      vt[6]  = '{4'b1011, 2, 7'b0000010, 4'h6, 1'b1, 0};
      vt[7]  = '{4'b0111, 3, 7'b1111000, 4'h7, 1'b1, 0};
      vt[8]  = '{4'b1110, 0, 7'b0000000, 4'h8, 1'b1, 0};
      vt[9]  = '{4'b1101, 1, 7'b0010000, 4'h9, 1'b1, 0};
      vt[10] = '{4'b1011, 2, 7'b0001000, 4'hA, 1'b1, 0};
      vt[11] = '{4'b0111, 3, 7'b0000011, 4'hB, 1'b1, 0};
      vt[12] = '{4'b1110, 0, 7'b1000110, 4'hC, 1'b1, 0};
      vt[13] = '{4'b1101, 1, 7'b0100001, 4'hD, 1'b1, 0};
      vt[14] = '{4'b1011, 2, 7'b0000110, 4'hE, 1'b1, 0};
      vt[15] = '{4'b0111, 3, 7'b0001110, 4'hF, 1'b1, 0};
      vt[16] = '{4'b1110, 0, 7'b1111111, 4'h0, 1'b0, 0};
      vt[17] = '{4'b1101, 1, 7'b0110110, 4'h0, 1'b0, 1};

      do_reset();

      // Scan: digit0=F, digit1=7, digit2=A, digit3=1, 8 cycles each.
      hold(4'b1110, 7'b0001110, 8);
      hold(4'b1101, 7'b1111000, 8);
      hold(4'b1011, 7'b0001000, 8);
      s0 = step_no;
      hold(4'b0111, 7'b1111001, 8);
      chk("scan_digits", 32'(digits), 32'h1A7F);
      chk("scan_valid", 32'(digit_valid), 32'hF);
      chk("scan_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("scan_frame_edge", 32'(frame_at), 32'(s0 + 5));
      chk("scan_errors", 32'(bad_cnt + multi_cnt), 32'd0);

      // Short dwell: 3 cycles on digit 0, 2 on digit 1, then dark.
      hold(4'b1110, 7'b0100100, 3);
      hold(4'b1101, 7'b0100100, 2);
      hold(4'b1111, 7'b1111111, 4);
      chk("dwell_digits", 32'(digits), 32'h1A7F);
      chk("dwell_frame", 32'(frame_cnt), 32'd1);

      // Blank then illegal on digit 2.
      hold(4'b1011, 7'b1111111, 8);
      chk("blank_nib", 32'(digits[11:8]), 32'd0);
      chk("blank_vld", 32'(digit_valid[2]), 32'd0);
      chk("blank_bad", 32'(bad_cnt), 32'd0);
      hold(4'b1011, 7'b1010101, 8);
      chk("illegal_nib", 32'(digits[11:8]), 32'd0);
      chk("illegal_vld", 32'(digit_valid[2]), 32'd0);
      chk("illegal_bad", 32'(bad_cnt), 32'd1);

      // Multi-anode for 6 cycles.
      multi_cnt = 0;
      hold(4'b1100, 7'b0000000, 6);
      hold(4'b1111, 7'b1111111, 2);
      chk("multi_cnt", 32'(multi_cnt), 32'd6);
      chk("multi_no_capture", 32'(digits), 32'h107F);

      // Reset after 2 stable cycles, then same value held.
      hold(4'b1110, 7'b0010010, 3);
      rst = 1'b1;
      step(4'b1110, 7'b0010010);
      chk("rst_mid_outputs", 32'({digits, digit_valid, frame_done, bad_pattern, multi_err}), 32'd0);
      rst = 1'b0;
      hold(4'b1110, 7'b0010010, 4);
      chk("rst_no_early", 32'({digits[3:0], digit_valid[0]}), 32'd0);
      step(4'b1110, 7'b0010010);
      chk("rst_capture", 32'({digits[3:0], digit_valid[0]}), 32'h0B);

      // Repeat captures of digit 0 do not complete a frame.
      do_reset();
      for (int r = 0; r < 3; r++) begin
         hold(4'b1110, 7'b0110000, 6);
         hold(4'b1111, 7'b1111111, 2);
      end
      hold(4'b1101, 7'b0110000, 6);
      hold(4'b1011, 7'b0110000, 6);
      chk("repeat_no_frame", 32'(frame_cnt), 32'd0);
      hold(4'b0111, 7'b0110000, 6);
      chk("repeat_frame", 32'(frame_cnt), 32'd1);

      // Glyph table, each vector held long enough to capture once.
      for (int i = 0; i < 18; i++) begin
         bad_cnt = 0;
         hold(vt[i].an, vt[i].seg, 6);
         chk("tab_nib", 32'(digits[4*vt[i].idx +: 4]), 32'(vt[i].nib));
         chk("tab_vld", 32'(digit_valid[vt[i].idx]), 32'(vt[i].vld));
         chk("tab_bad", 32'(bad_cnt), 32'(vt[i].bad));
      end

      // Random segments against the model.
      for (int r = 0; r < 300; r++) begin
         k = $urandom_range(0, 9);
         if (k == 0)      a = 4'hF;
         else if (k == 1) begin
            a = 4'($urandom);
            if ($countones(~a) < 2) a = 4'b0000;
         end else         a = ~(4'b0001 << $urandom_range(0, 3));
         k = $urandom_range(0, 9);
         if (k == 0)      s = 7'b1111111;
         else if (k == 1) s = 7'($urandom);
         else             s = glyph_of($urandom_range(0, 15));
         hl = $urandom_range(1, 7);
         if ($urandom_range(0, 40) == 0) rst = 1'b1;
         step(a, s);
         rst = 1'b0;
         hold(a, s, hl - 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_readback.md
# seg7_readback

Passive monitor that watches the multiplexed, active-low anode and segment lines driven to the stopwatch's 4-digit 7-segment display and recovers the hexadecimal value shown on each digit. It is the decode direction of the display path: hex nibble to segment pattern on the drive side, segment pattern back to nibble here. It sits in parallel with the display outputs for self-check and scoreboard use. It drives nothing onto the display pins.

## Interface
- DIGITS, 4: number of multiplexed digits (anode lines).
- SETTLE, 4: consecutive cycles {an, seg} must be unchanged before a capture; legal range 1..255.
- clk  in  1: system clock.
- rst  in  1: synchronous, active-high reset.
- an  in  DIGITS: anode enables, active-low; bit i low selects digit i.
- seg  in  7: segment lines, active-low, ordered {g,f,e,d,c,b,a}.
- digits  out  4*DIGITS: recovered nibbles; digit i occupies [4i+3:4i].
- digit_valid  out  DIGITS: bit i is 1 when digit i last captured a legal hex glyph.
- frame_done  out  1: one-cycle pulse when every digit has been captured since the previous pulse.
- bad_pattern  out  1: one-cycle pulse when a capture sees a non-hex, non-blank pattern.
- multi_err  out  1: one-cycle pulse when more than one anode is low in a sample.

## Operation
- Input stage: {an, seg} is registered every cycle into s_q. Comparison uses the incoming value against s_q.
- Legal glyphs for seg, value:pattern:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Blank pattern: 1111111.
- State machine with states IDLE, SETTLING, and HELD.
- IDLE: entered when s_q has zero or more than one anode low.
  - Stability counter is held at 0.
  - When the incoming sample has exactly one anode low, the FSM moves to SETTLING.
- SETTLING: the counter increments each cycle the incoming sample equals s_q.
  - Any change resets the counter to 0. The FSM stays in SETTLING, or goes to IDLE if the anode count is not exactly one.
  - When the counter reaches SETTLE-1 and the sample is unchanged, the FSM captures and moves to HELD.
- HELD: no recapture. Any change to {an, seg} goes to SETTLING with the counter at 0, or to IDLE per the anode rule.
- Capture on digit i (the index of the low anode):
  - Legal glyph: digits[i] is set to the glyph value and digit_valid[i] to 1.
  - Blank: digits[i] is set to 0 and digit_valid[i] to 0. No error.
  - Any other pattern: digits[i] is set to 0, digit_valid[i] to 0, and bad_pattern pulses.
  - In all three cases bit i of the internal seen mask is set.
- Frame completion: when a capture makes the seen mask all ones, frame_done pulses and the mask clears in the same update.
  - A repeated capture of an already-seen digit does not advance the frame.
- multi_err pulses on every cycle in which the registered sample has two or more anode bits low.
- Other digits' outputs are unaffected by a capture.

## Timing
- Reset (synchronous, rst high at an edge) sets:
  - digits = 0, digit_valid = 0, frame_done = 0, bad_pattern = 0, multi_err = 0.
  - s_q = {all ones, all ones}, state = IDLE, counter = 0, seen mask = 0.
- Reset mid-capture discards partial settling. No capture occurs on the reset edge.
- Latency: suppose a new value is first present before edge k and held constant.
  - digits, digit_valid, frame_done and bad_pattern update at edge k+SETTLE.
  - Exactly one capture occurs per stable period.
- A value held for SETTLE-1 cycles, then changed, produces no capture.
- frame_done and bad_pattern are registered. They are high only for the cycle after the capturing edge.
- multi_err is asserted the cycle after the offending sample is registered.
- Simultaneous events: a capture that completes the frame with an illegal pattern pulses both bad_pattern and frame_done.

## Test plan
- Scan test (SETTLE=4):
  - Stimulus: drive digits 3..0 with glyphs for 0x1, 0xA, 0x7, 0xF, each held 8 cycles, in scan order 0,1,2,3.
  - Required: digits = 0x1A7F, digit_valid = 1111, a single frame_done pulse at the fourth capture edge (k+4), and no errors.
- Short dwell:
  - Stimulus: hold an = 1110, seg = 0100100 for 3 cycles, then switch to an = 1101.
  - Required: no update to digit 0, and no capture.
- Blank and illegal:
  - Stimulus: digit 2 shows 1111111, then 1010101.
  - Required: digit 2 reads 0 with digit_valid[2] = 0 both times. bad_pattern pulses only for the second capture.
- Multi-anode:
  - Stimulus: an = 1100 for 6 cycles.
  - Required: multi_err high on each of those cycles (one cycle delayed), FSM in IDLE, no capture.
- Reset mid-operation:
  - Stimulus: assert rst during SETTLING after 2 stable cycles. Release, then hold the same value.
  - Required: all outputs 0 at reset. Capture occurs SETTLE cycles after release, not earlier.
- Repeat without frame:
  - Stimulus: capture digit 0 three times, then capture digits 1..3.
  - Required: frame_done pulses once, only at the digit 3 capture.
